// File: rtl/traffic_pkg.sv
// Shared lamp and fault encodings for the lamp conflict monitor.
package traffic_pkg;

  localparam int unsigned NUM_LANES    = 4;
  localparam int unsigned LAMP_RED_BIT = 0;
  localparam int unsigned LAMP_YEL_BIT = 1;
  localparam int unsigned LAMP_GRN_BIT = 2;

  typedef enum logic [2:0] {
    LAMP_DARK  = 3'd0,
    LAMP_RED   = 3'd1,
    LAMP_YEL   = 3'd2,
    LAMP_GRN   = 3'd3,
    LAMP_MULTI = 3'd4
  } lamp_e;

  typedef enum logic [2:0] {
    FC_NONE         = 3'd0,
    FC_MULTI_LAMP   = 3'd1,
    FC_CONFLICT     = 3'd2,
    FC_SKIP_YELLOW  = 3'd3,
    FC_SHORT_YELLOW = 3'd4,
    FC_BAD_ORDER    = 3'd5,
    FC_CLEARANCE    = 3'd6
  } fault_code_t;

  function automatic lamp_e decode_lamp(input logic [0:2] lamps);
    lamp_e res;
    case ({lamps[LAMP_RED_BIT], lamps[LAMP_YEL_BIT], lamps[LAMP_GRN_BIT]})
      3'b000:  res = LAMP_DARK;
      3'b100:  res = LAMP_RED;
      3'b010:  res = LAMP_YEL;
      3'b001:  res = LAMP_GRN;
      default: res = LAMP_MULTI;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/lane_tracker.sv
// Per-lane lamp history: decodes one head, tracks yellow dwell and
// red clearance time, and flags illegal sequence steps.
module lane_tracker
  import traffic_pkg::*;
#(
  parameter int unsigned MIN_YELLOW = 3,
  parameter int unsigned MIN_ALLRED = 2,
  parameter int unsigned CW         = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [0:2] lamp_i,
  output logic       multi_o,
  output logic       active_o,
  output logic       skip_yellow_o,
  output logic       short_yellow_o,
  output logic       bad_order_o,
  output logic       grn_entry_o,
  output logic       clr_open_o
);

  localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
  localparam logic [CW-1:0] MIN_YEL_C = CW'(MIN_YELLOW);
  localparam logic [CW-1:0] MIN_CLR_C = CW'(MIN_ALLRED);

  lamp_e         cur_s;
  lamp_e         prev_q;
  logic [CW-1:0] yel_cnt_q, yel_cnt_d;
  logic [CW-1:0] clr_cnt_q, clr_cnt_d;
  logic          yel_to_red_s;

  assign cur_s        = decode_lamp(lamp_i);
  assign yel_to_red_s = (prev_q == LAMP_YEL) && (cur_s == LAMP_RED);

  // Counter next-state: yellow dwell restarts at 1 on entry, clearance restarts on YEL->RED.
  always_comb begin
    yel_cnt_d = {CW{1'b0}};
    clr_cnt_d = clr_cnt_q;
    if (cur_s != LAMP_YEL) begin
      yel_cnt_d = {CW{1'b0}};
    end else if (prev_q != LAMP_YEL) begin
      yel_cnt_d = CNT_ONE;
    end else if (yel_cnt_q != CNT_MAX) begin
      yel_cnt_d = yel_cnt_q + CNT_ONE;
    end else begin
      yel_cnt_d = yel_cnt_q;
    end
    if (yel_to_red_s) begin
      clr_cnt_d = {CW{1'b0}};
    end else if (clr_cnt_q != CNT_MAX) begin
      clr_cnt_d = clr_cnt_q + CNT_ONE;
    end else begin
      clr_cnt_d = clr_cnt_q;
    end
  end

  // Lane history registers; clearance starts saturated so power-up greens are legal.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q    <= LAMP_DARK;
      yel_cnt_q <= {CW{1'b0}};
      clr_cnt_q <= CNT_MAX;
    end else begin
      prev_q    <= cur_s;
      yel_cnt_q <= yel_cnt_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  assign multi_o        = (cur_s == LAMP_MULTI);
  assign active_o       = (cur_s == LAMP_YEL) || (cur_s == LAMP_GRN);
  assign skip_yellow_o  = (prev_q == LAMP_GRN) && (cur_s == LAMP_RED);
  assign short_yellow_o = yel_to_red_s && (yel_cnt_q < MIN_YEL_C);
  assign bad_order_o    = ((prev_q == LAMP_YEL) && (cur_s == LAMP_GRN)) ||
                          ((prev_q == LAMP_RED) && (cur_s == LAMP_YEL));
  assign grn_entry_o    = (cur_s == LAMP_GRN) && (prev_q != LAMP_GRN);
  assign clr_open_o     = (clr_cnt_q >= MIN_CLR_C);

endmodule

// File: rtl/traffic_monitor.sv
// Independent lamp conflict monitor: checks all four heads each cycle and
// latches the first safety violation, forcing the controller to all-red.
module traffic_monitor
  import traffic_pkg::*;
#(
  parameter int unsigned MIN_YELLOW = 3,
  parameter int unsigned MIN_ALLRED = 2,
  parameter int unsigned CW         = 8,
  parameter logic [15:0] CONFLICT   = 16'h5A5A
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0][0:2] ltfs,
  input  logic            attention,
  input  logic            clear,
  output logic            fault,
  output logic [2:0]      fault_code,
  output logic [1:0]      fault_lane,
  output logic [3:0]      force_reds
);

  logic [3:0]      multi_s, active_s, skip_s, short_s, order_s, grn_entry_s, clr_open_s;
  logic [6:1][3:0] viol_s;
  logic            viol_any_s;
  fault_code_t     code_s;
  logic [1:0]      lane_s;

  logic            fault_q;
  fault_code_t     fault_code_q;
  logic [1:0]      fault_lane_q;
  logic [3:0]      force_reds_q;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lane_tracker #(
      .MIN_YELLOW(MIN_YELLOW),
      .MIN_ALLRED(MIN_ALLRED),
      .CW        (CW)
    ) u_lane (
      .clk_i         (clk),
      .rst_ni        (rst),
      .lamp_i        (ltfs[g]),
      .multi_o       (multi_s[g]),
      .active_o      (active_s[g]),
      .skip_yellow_o (skip_s[g]),
      .short_yellow_o(short_s[g]),
      .bad_order_o   (order_s[g]),
      .grn_entry_o   (grn_entry_s[g]),
      .clr_open_o    (clr_open_s[g])
    );
  end

  // Per-code violation vectors; sequence-type checks drop out in flashing mode.
  always_comb begin
    viol_s    = '0;
    viol_s[1] = multi_s;
    for (int i = 0; i < NUM_LANES; i++) begin
      for (int j = 0; j < NUM_LANES; j++) begin
        viol_s[2][i] = viol_s[2][i] |
                       ((j > i) && CONFLICT[4*i+j] && active_s[i] && active_s[j]);
        viol_s[6][i] = viol_s[6][i] |
                       (!attention && CONFLICT[4*i+j] && grn_entry_s[i] && !clr_open_s[j]);
      end
    end
    if (!attention) begin
      viol_s[3] = skip_s;
      viol_s[4] = short_s;
      viol_s[5] = order_s;
    end else begin
      viol_s[3] = 4'h0;
      viol_s[4] = 4'h0;
      viol_s[5] = 4'h0;
    end
  end

  // Priority encode: scanning from highest to lowest lets lowest code, then lowest lane, win.
  always_comb begin
    code_s = FC_NONE;
    lane_s = 2'd0;
    for (int c = 6; c >= 1; c--) begin
      for (int l = NUM_LANES - 1; l >= 0; l--) begin
        code_s = viol_s[c][l] ? fault_code_t'(3'(c)) : code_s;
        lane_s = viol_s[c][l] ? 2'(l) : lane_s;
      end
    end
    viol_any_s = |viol_s;
  end

  // Sticky fault latch; a fresh violation beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fault_q      <= 1'b0;
      fault_code_q <= FC_NONE;
      fault_lane_q <= 2'd0;
      force_reds_q <= 4'h0;
    end else if (viol_any_s && (!fault_q || clear)) begin
      fault_q      <= 1'b1;
      fault_code_q <= code_s;
      fault_lane_q <= lane_s;
      force_reds_q <= 4'hF;
    end else if (clear) begin
      fault_q      <= 1'b0;
      fault_code_q <= FC_NONE;
      fault_lane_q <= 2'd0;
      force_reds_q <= 4'h0;
    end
  end

  assign fault      = fault_q;
  assign fault_code = fault_code_q;
  assign fault_lane = fault_lane_q;
  assign force_reds = force_reds_q;

endmodule

// File: tb/tb_traffic_monitor.sv
// Directed self-checking bench for traffic_monitor.
module tb_traffic_monitor;

  localparam logic [0:2] L_DARK  = 3'b000;
  localparam logic [0:2] L_RED   = 3'b100;
  localparam logic [0:2] L_YEL   = 3'b010;
  localparam logic [0:2] L_GRN   = 3'b001;
  localparam logic [0:2] L_RY    = 3'b110;
  localparam logic [9:0] OK_IDLE = 10'b0_000_00_0000;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0][0:2] ltfs;
  logic            attention;
  logic            clear;
  logic            fault;
  logic [2:0]      fault_code;
  logic [1:0]      fault_lane;
  logic [3:0]      force_reds;
  logic [9:0]      obs;
  int              checks = 0;
  int              errors = 0;

  traffic_monitor dut (
    .clk       (clk),
    .rst       (rst),
    .ltfs      (ltfs),
    .attention (attention),
    .clear     (clear),
    .fault     (fault),
    .fault_code(fault_code),
    .fault_lane(fault_lane),
    .force_reds(force_reds)
  );

  always #5 clk = ~clk;

  assign obs = {fault, fault_code, fault_lane, force_reds};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic [0:2] v);
    for (int i = 0; i < 4; i++) ltfs[i] = v;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    set_all(L_DARK);
    attention = 1'b0;
    clear = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_all(L_DARK);
    attention = 1'b0;
    clear = 1'b0;
    #1;
    checks++;
    if (obs !== OK_IDLE) begin errors++; $display("FAIL reset_values got %b exp %b", obs, OK_IDLE); end
    rst = 1'b1;
    tick();
    set_all(L_RED);
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (obs !== OK_IDLE) begin errors++; $display("FAIL reset_all_red cyc %0d got %b exp %b", k, obs, OK_IDLE); end
    end
  endtask

  task automatic test_normal_cycle();
    do_reset();
    set_all(L_RED); tick();
    ltfs[0] = L_GRN; tick(); tick();
    ltfs[0] = L_YEL; tick(); tick(); tick();
    ltfs[0] = L_RED; tick(); tick(); tick();
    ltfs[1] = L_GRN; tick();
    checks++;
    if (obs !== OK_IDLE) begin errors++; $display("FAIL normal_cycle got %b exp %b", obs, OK_IDLE); end
    tick(); tick();
    checks++;
    if (obs !== OK_IDLE) begin errors++; $display("FAIL normal_hold got %b exp %b", obs, OK_IDLE); end
  endtask

  task automatic test_clearance();
    do_reset();
    set_all(L_RED); tick();
    ltfs[0] = L_GRN; tick();
    ltfs[0] = L_YEL; tick(); tick(); tick();
    ltfs[0] = L_RED; tick(); tick();
    checks++;
    if (obs !== OK_IDLE) begin errors++; $display("FAIL clearance_pre got %b exp %b", obs, OK_IDLE); end
    ltfs[1] = L_GRN; tick();
    checks++;
    if (obs !== 10'b1_110_01_1111) begin errors++; $display("FAIL clearance got %b exp %b", obs, 10'b1_110_01_1111); end
  endtask

  task automatic test_short_yellow();
    do_reset();
    set_all(L_RED); tick();
    ltfs[0] = L_GRN; tick();
    ltfs[0] = L_YEL; tick(); tick();
    checks++;
    if (obs !== OK_IDLE) begin errors++; $display("FAIL short_yellow_pre got %b exp %b", obs, OK_IDLE); end
    ltfs[0] = L_RED; tick();
    checks++;
    if (obs !== 10'b1_100_00_1111) begin errors++; $display("FAIL short_yellow got %b exp %b", obs, 10'b1_100_00_1111); end
    ltfs[0] = L_GRN; ltfs[1] = L_GRN; tick();
    checks++;
    if (obs !== 10'b1_100_00_1111) begin errors++; $display("FAIL sticky got %b exp %b", obs, 10'b1_100_00_1111); end
    clear = 1'b1; tick(); clear = 1'b0;
    checks++;
    if (obs !== 10'b1_010_00_1111) begin errors++; $display("FAIL clear_vs_new got %b exp %b", obs, 10'b1_010_00_1111); end
  endtask

  task automatic test_conflict();
    do_reset();
    set_all(L_RED); tick();
    ltfs[0] = L_GRN; ltfs[1] = L_GRN; tick();
    checks++;
    if (obs !== 10'b1_010_00_1111) begin errors++; $display("FAIL conflict_01 got %b exp %b", obs, 10'b1_010_00_1111); end
    do_reset();
    set_all(L_RED); tick();
    ltfs[0] = L_GRN; ltfs[2] = L_GRN; tick(); tick();
    checks++;
    if (obs !== OK_IDLE) begin errors++; $display("FAIL compatible_02 got %b exp %b", obs, OK_IDLE); end
  endtask

  task automatic test_priority_clear();
    do_reset();
    set_all(L_RED); tick();
    ltfs[1] = L_GRN; tick();
    ltfs[2] = L_RY; ltfs[1] = L_RED; tick();
    checks++;
    if (obs !== 10'b1_001_10_1111) begin errors++; $display("FAIL priority got %b exp %b", obs, 10'b1_001_10_1111); end
    ltfs[2] = L_RED; clear = 1'b1; tick(); clear = 1'b0;
    checks++;
    if (obs !== OK_IDLE) begin errors++; $display("FAIL clear got %b exp %b", obs, OK_IDLE); end
  endtask

  task automatic test_sequence_codes();
    do_reset();
    set_all(L_RED); tick();
    ltfs[2] = L_YEL; tick();
    checks++;
    if (obs !== 10'b1_101_10_1111) begin errors++; $display("FAIL bad_order got %b exp %b", obs, 10'b1_101_10_1111); end
    do_reset();
    set_all(L_RED); tick();
    ltfs[3] = L_GRN; tick();
    ltfs[3] = L_RED; tick();
    checks++;
    if (obs !== 10'b1_011_11_1111) begin errors++; $display("FAIL skip_yellow got %b exp %b", obs, 10'b1_011_11_1111); end
  endtask

  task automatic test_attention();
    do_reset();
    attention = 1'b1;
    for (int k = 0; k < 6; k++) begin
      ltfs[0] = (k % 2 == 0) ? L_YEL : L_DARK;
      ltfs[2] = (k % 2 == 0) ? L_YEL : L_DARK;
      ltfs[1] = (k % 2 == 0) ? L_DARK : L_YEL;
      ltfs[3] = (k % 2 == 0) ? L_DARK : L_YEL;
      tick();
      checks++;
      if (obs !== OK_IDLE) begin errors++; $display("FAIL flashing cyc %0d got %b exp %b", k, obs, OK_IDLE); end
    end
    set_all(L_DARK); ltfs[0] = L_YEL; tick();
    ltfs[0] = L_RED; tick();
    checks++;
    if (obs !== OK_IDLE) begin errors++; $display("FAIL masked_short got %b exp %b", obs, OK_IDLE); end
    attention = 1'b0;
    ltfs[3] = L_YEL; tick();
    ltfs[3] = L_RED; tick();
    checks++;
    if (obs !== 10'b1_100_11_1111) begin errors++; $display("FAIL short_lane3 got %b exp %b", obs, 10'b1_100_11_1111); end
  endtask

  task automatic test_reset_mid();
    rst = 1'b0;
    #1;
    checks++;
    if (obs !== OK_IDLE) begin errors++; $display("FAIL async_reset got %b exp %b", obs, OK_IDLE); end
    set_all(L_DARK);
    rst = 1'b1;
    tick();
    checks++;
    if (obs !== OK_IDLE) begin errors++; $display("FAIL post_reset got %b exp %b", obs, OK_IDLE); end
  endtask

  initial begin
    test_reset();
    test_normal_cycle();
    test_clearance();
    test_short_yellow();
    test_conflict();
    test_priority_clear();
    test_sequence_codes();
    test_attention();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_monitor.md
# traffic_monitor

Independent conflict monitor that reads the four lamp vectors driven by `top_level` and checks them against the signal-safety rules: one lamp per head, no conflicting greens, legal sequencing, minimum yellow and all-red clearance. On the first violation it latches a sticky fault with a code and lane, and drives `force_reds` to all ones so the controller is pushed into all-red. It sits beside `top_level`, fed by its `ltfs` bus, and is the consumer end of the lamp interface.

## Interface
- `MIN_YELLOW`, default 3: minimum cycles a lane must show yellow before red.
- `MIN_ALLRED`, default 2: minimum cycles after a lane enters red from yellow before a conflicting lane may go green.
- `CW`, default 8: width of per-lane saturating counters; `MIN_YELLOW` and `MIN_ALLRED` must be < 2**CW.
- `CONFLICT`, default 16'h5A5A: conflict matrix; bit `4*i+j` set means lanes i and j conflict (symmetric, diagonal zero). Default makes 0/2 and 1/3 compatible.
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `ltfs`  in  [3:0][0:2]  lamps per lane; bit 0 red, 1 yellow, 2 green.
- `attention`  in  1  controller in flashing-yellow mode; sequence, yellow and clearance checks suspended.
- `clear`  in  1  clears latched fault.
- `fault`  out  1  sticky fault flag.
- `fault_code`  out  3  code of latched fault.
- `fault_lane`  out  2  lane of latched fault.
- `force_reds`  out  4  4'hF while `fault`, else 4'h0.

## Operation
- Lamp decode per lane: DARK 000, RED 100, YEL 010, GRN 001; any other value is MULTI.
- Per lane registers: `prev` lamp state, `yel_cnt` (cycles in YEL, set to 1 on entry, +1 saturating), `clr_cnt` (cycles since YEL->RED, saturating; cleared on YEL->RED).
- Fault codes: 0 NONE, 1 MULTI_LAMP, 2 CONFLICT (two conflicting lanes both in YEL/GRN, reported at lower lane), 3 SKIP_YELLOW (GRN->RED), 4 SHORT_YELLOW (YEL->RED with `yel_cnt` < MIN_YELLOW), 5 BAD_ORDER (YEL->GRN or RED->YEL), 6 CLEARANCE (lane enters GRN while a conflicting lane has `clr_cnt` < MIN_ALLRED).
- Codes 1 and 2 always checked; codes 3-6 masked while `attention`=1.
- Transitions to/from DARK are legal (startup and flashing).
- Simultaneous violations: lowest code wins, then lowest lane.
- First fault latched; later violations ignored until `clear`.
- `clear` with a new violation the same cycle: the new violation is latched (fault wins).
- Counters keep tracking while faulted.

## Timing
- Reset values: `fault`=0, `fault_code`=0, `fault_lane`=0, `force_reds`=0; `prev`=DARK; `yel_cnt`=0; `clr_cnt` saturated (all ones) so no clearance fault right after reset.
- Detection latency: violation present on `ltfs` at edge N -> `fault`, code, lane, `force_reds` valid after edge N (registered, one cycle).
- `clear` sampled at edge N -> outputs 0 after edge N (unless a new violation is present).
- Reset asserted mid-operation returns all state to reset values immediately.

## Structure
- `traffic_pkg`: lamp enum (DARK/RED/YEL/GRN/MULTI), `fault_code_t` enum, lamp bit-index constants.
- Sub-module `lane_tracker` (instantiated 4x): decodes one lane, holds `prev`/`yel_cnt`/`clr_cnt`, outputs per-lane sequence-fault flags, GRN-entry strobe and clearance-open flag. Top does conflict check, priority encode, latch.

## Test plan
- Reset, all lanes DARK then RED for 10 cycles -> `fault`=0, `force_reds`=0.
- Lane 0 RED->GRN->YEL(3 cycles)->RED, wait 2, lane 1 RED->GRN -> no fault.
- Lane 0 YEL for 2 cycles then RED -> `fault`=1, code 4, lane 0, `force_reds`=4'hF one cycle later.
- Lanes 0 and 1 GRN same cycle -> code 2, lane 0; lanes 0 and 2 GRN -> no fault.
- Lane 2 `ltfs`=110 and lane 1 GRN->RED same cycle -> code 1, lane 2 (priority); `clear` -> all outputs 0.
- `attention`=1, all lanes toggling 010/000 -> no fault; lane 3 YEL->RED after 1 cycle with `attention`=0 -> code 4, lane 3.
